// File: rtl/fp_pkg.sv
// Shared FP32 types, constants and FSM state encoding for the stream accumulator.
package fp_pkg;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam fp32_t FP_ZERO    = 32'h0000_0000;
  localparam fp32_t FP_POS_INF = 32'h7F80_0000;
  localparam fp32_t FP_NEG_INF = 32'hFF80_0000;
  localparam int    EXP_BIAS   = 127;
  localparam int    EXP_MAX    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_NORM  = 2'd3
  } state_t;

  // Zero and denormal encodings both collapse to +0.
  function automatic fp32_t flush(fp32_t x);
    return (x.exp == 8'h00) ? FP_ZERO : x;
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// Combinational 27-bit leading-zero counter; an all-zero input yields 27.
module fp_lzc (
  input  logic [26:0] val,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++)
      if (val[i]) cnt = 5'(26 - i);
  end
endmodule

// File: rtl/fp_stream_accum.sv
// Multi-cycle FP32 running-sum accumulator: IDLE -> ALIGN -> ADD -> NORM, emits total on last.
module fp_stream_accum
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [31:0] in_FP,
  input  logic        in_last,
  output logic        in_rdy,
  output logic [31:0] sum_FP,
  output logic        sum_vld,
  output logic        busy
);
  state_t state;
  fp32_t  acc, op;
  logic   last_q;

  logic [25:0] big_q, small_q;
  logic [7:0]  exp_q;
  logic        sign_q, sub_q, inf_q, inf_sign_q;

  logic [26:0] raw_q;
  logic [7:0]  rexp_q;
  logic        rsign_q, rinf_q, rinf_sign_q;

  assign in_rdy = (state == ST_IDLE);
  assign busy   = (state != ST_IDLE);

  fp32_t       a_op, a_acc, a_big, a_sml;
  logic        a_swap, a_inf, a_inf_sign;
  logic [7:0]  a_diff;
  logic [23:0] sig_big, sig_sml;
  logic [25:0] sml_sh;

  always_comb begin
    a_op   = flush(op);
    a_acc  = flush(acc);
    a_swap = {a_op.exp, a_op.man} > {a_acc.exp, a_acc.man};
    a_big  = a_swap ? a_op : a_acc;
    a_sml  = a_swap ? a_acc : a_op;
    a_diff = a_big.exp - a_sml.exp;
    sig_big = (a_big.exp == 8'h00) ? 24'h0 : {1'b1, a_big.man};
    sig_sml = (a_sml.exp == 8'h00) ? 24'h0 : {1'b1, a_sml.man};
    sml_sh  = (a_diff > 8'd25) ? 26'h0 : ({sig_sml, 2'b00} >> a_diff);
    a_inf      = (acc.exp == 8'hFF) || (op.exp == 8'hFF);
    a_inf_sign = (op.exp == 8'hFF) ? op.sign : acc.sign;
  end

  logic [4:0]        lz;
  logic [26:0]       n_sh;
  logic signed [9:0] n_exp;
  fp32_t             n_res;

  fp_lzc u_lzc (.val(raw_q), .cnt(lz));

  // Shifting the leading one to bit 26 covers both the carry and the cancellation case.
  always_comb begin
    n_sh  = raw_q << lz;
    n_exp = $signed({2'b00, rexp_q}) + 10'sd1 - $signed({5'b00000, lz});
    if (rinf_q)
      n_res = rinf_sign_q ? FP_NEG_INF : FP_POS_INF;
    else if (raw_q == 27'h0 || n_exp <= 10'sd0)
      n_res = FP_ZERO;
    else if (n_exp >= 10'(EXP_MAX))
      n_res = rsign_q ? FP_NEG_INF : FP_POS_INF;
    else
      n_res = '{sign: rsign_q, exp: n_exp[7:0], man: 23'(n_sh >> 3)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= FP_ZERO;
      op      <= FP_ZERO;
      last_q  <= 1'b0;
      sum_FP  <= FP_ZERO;
      sum_vld <= 1'b0;
      big_q   <= '0;
      small_q <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      inf_q   <= 1'b0;
      inf_sign_q  <= 1'b0;
      raw_q   <= '0;
      rexp_q  <= '0;
      rsign_q <= 1'b0;
      rinf_q  <= 1'b0;
      rinf_sign_q <= 1'b0;
    end else begin
      sum_vld <= 1'b0;
      if (clr) begin
        state <= ST_IDLE;
        acc   <= FP_ZERO;
      end else begin
        case (state)
          ST_IDLE: if (in_vld) begin
            op     <= in_FP;
            last_q <= in_last;
            state  <= ST_ALIGN;
          end
          ST_ALIGN: begin
            big_q      <= {sig_big, 2'b00};
            small_q    <= sml_sh;
            exp_q      <= a_big.exp;
            sign_q     <= a_big.sign;
            sub_q      <= a_big.sign ^ a_sml.sign;
            inf_q      <= a_inf;
            inf_sign_q <= a_inf_sign;
            state      <= ST_ADD;
          end
          ST_ADD: begin
            raw_q       <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                 : ({1'b0, big_q} + {1'b0, small_q});
            rexp_q      <= exp_q;
            rsign_q     <= sign_q;
            rinf_q      <= inf_q;
            rinf_sign_q <= inf_sign_q;
            state       <= ST_NORM;
          end
          ST_NORM: begin
            state <= ST_IDLE;
            if (last_q) begin
              sum_FP  <= n_res;
              sum_vld <= 1'b1;
              acc     <= FP_ZERO;
            end else begin
              acc <= n_res;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
